extram_stream_bridge: RTL and testbench

EXTRAM_STREAM_BRIDGE -- requirements
Module: extram_stream_bridge

---
 rtl/extram_bridge_pkg.sv | 28 ++
 rtl/word_fifo.sv | 48 ++++
 rtl/extram_stream_bridge.sv | 195 +++++++++++++++++++
 tb/tb_extram_stream_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/extram_bridge_pkg.sv
// Shared definitions for the external-RAM stream bridge: register map,
// STATUS/CTRL bit positions and the TX serializer state encoding.
package extram_bridge_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_addr_t;

  localparam int unsigned ST_TX_ERR   = 8;
  localparam int unsigned ST_TX_OVF   = 9;
  localparam int unsigned ST_RX_UNF   = 10;
  localparam int unsigned ST_RX_OVF   = 11;
  localparam int unsigned ST_RX_COUNT = 16;

  localparam int unsigned CT_TX_FLUSH = 0;
  localparam int unsigned CT_RX_FLUSH = 1;
  localparam int unsigned CT_IE_RX    = 8;
  localparam int unsigned CT_IE_TX    = 9;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

endpackage

// File: rtl/word_fifo.sv
// 32-bit word FIFO with combinational head; a pop frees its slot for a push
// in the same cycle, and flush discards both.
module word_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [31:0]           data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [31:0]           head
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (nrst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/extram_stream_bridge.sv
// CPU external-RAM slave bridging 32-bit register accesses to 8-bit TX/RX
// byte streams through two word FIFOs, with sticky status and a level IRQ.
module extram_stream_bridge
  import extram_bridge_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned TX_IRQ_LEVEL = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] extram_a,
  input  logic [31:0] extram_d_out,
  input  logic        extram_cs,
  input  logic        extram_oe,
  input  logic [3:0]  extram_wstrb,
  output logic [31:0] extram_d_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  reg_addr_t addr;
  logic      rd;
  logic      wr;
  logic      unused_addr;

  assign addr        = reg_addr_t'(extram_a[3:2]);
  assign rd          = extram_cs && extram_oe;
  assign wr          = extram_cs && (extram_wstrb != 4'h0);
  assign unused_addr = ^{extram_a[15:4], extram_a[1:0]};

  logic       ie_rx;
  logic       ie_tx;
  logic       tx_flush;
  logic       rx_flush;
  logic [3:0] flags;
  logic [3:0] flag_set;
  logic [3:0] flag_clr;

  assign tx_flush = wr && addr == REG_CTRL && extram_wstrb[0] && extram_d_out[CT_TX_FLUSH];
  assign rx_flush = wr && addr == REG_CTRL && extram_wstrb[0] && extram_d_out[CT_RX_FLUSH];
  assign flag_clr = (wr && addr == REG_STATUS && extram_wstrb[1])
                    ? extram_d_out[ST_RX_OVF:ST_TX_ERR] : 4'h0;

  // TX side
  logic                tx_push_req;
  logic                tx_load;
  logic                tx_full;
  logic                tx_empty;
  logic [DEPTH_LOG2:0] tx_count;
  logic [31:0]         tx_head;
  tx_state_t           tx_state;
  tx_state_t           tx_state_next;
  logic [1:0]          tx_idx;
  logic [31:0]         tx_shift;

  assign tx_push_req = wr && addr == REG_TXDATA && extram_wstrb == 4'hF;

  word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) tx_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (tx_push_req),
    .pop     (tx_load),
    .flush   (tx_flush),
    .data_in (extram_d_out),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count),
    .head    (tx_head)
  );

  always_ff @(posedge clk) begin
    if (nrst) tx_state <= TX_IDLE;
    else      tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    if (tx_flush) begin
      tx_state_next = TX_IDLE;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tx_empty) tx_state_next = TX_SEND;
        TX_SEND: if (tx_ready && tx_idx == 2'd3 && tx_empty) tx_state_next = TX_IDLE;
        default: tx_state_next = TX_IDLE;
      endcase
    end
  end

  // tx_load doubles as the FIFO pop: from IDLE, or back-to-back after byte 3
  always_comb begin
    tx_valid = (tx_state == TX_SEND);
    tx_data  = tx_valid ? tx_shift[7:0] : 8'h00;
    tx_load  = !tx_empty && ((tx_state == TX_IDLE) || (tx_valid && tx_ready && tx_idx == 2'd3));
  end

  always_ff @(posedge clk) begin
    if (nrst || tx_flush) begin
      tx_idx   <= '0;
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_idx   <= '0;
      tx_shift <= tx_head;
    end else if (tx_valid && tx_ready) begin
      tx_idx   <= tx_idx + 2'd1;
      tx_shift <= {8'h00, tx_shift[31:8]};
    end
  end

  // RX side
  logic                rx_pop_req;
  logic                rx_pop;
  logic                rx_accept;
  logic                rx_push;
  logic                rx_full;
  logic                rx_empty;
  logic [DEPTH_LOG2:0] rx_count;
  logic [31:0]         rx_head;
  logic [1:0]          rx_idx;
  logic [31:0]         rx_asm;

  assign rx_pop_req = rd && addr == REG_RXDATA;
  assign rx_pop     = rx_pop_req && !rx_empty;
  assign rx_ready   = !nrst && !(rx_idx == 2'd3 && rx_full && !rx_pop);
  assign rx_accept  = rx_valid && rx_ready;
  assign rx_push    = rx_accept && rx_idx == 2'd3;

  word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) rx_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (rx_push),
    .pop     (rx_pop_req),
    .flush   (rx_flush),
    .data_in ({rx_data, rx_asm[31:8]}),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count),
    .head    (rx_head)
  );

  // bytes enter at the top so byte 0 ends up lowest when byte 3 completes the word
  always_ff @(posedge clk) begin
    if (nrst || rx_flush) begin
      rx_idx <= '0;
      rx_asm <= '0;
    end else if (rx_accept) begin
      rx_idx <= rx_idx + 2'd1;
      rx_asm <= {rx_data, rx_asm[31:8]};
    end
  end

  // Status, control and interrupt
  assign flag_set = {rx_push && rx_flush,
                     rx_pop_req && rx_empty,
                     tx_push_req && tx_full && !tx_load,
                     wr && addr == REG_TXDATA && extram_wstrb != 4'hF};

  always_ff @(posedge clk) begin
    if (nrst) begin
      flags <= '0;
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      irq   <= 1'b0;
    end else begin
      flags <= (flags & ~flag_clr) | flag_set;
      if (wr && addr == REG_CTRL && extram_wstrb[1]) begin
        ie_rx <= extram_d_out[CT_IE_RX];
        ie_tx <= extram_d_out[CT_IE_TX];
      end
      irq <= (ie_rx && rx_count != '0) || (ie_tx && 32'(tx_count) <= TX_IRQ_LEVEL);
    end
  end

  always_comb begin
    extram_d_in = '0;
    case (addr)
      REG_RXDATA: if (!rx_empty) extram_d_in = rx_head;
      REG_STATUS: begin
        extram_d_in[DEPTH_LOG2:0]                  = tx_count;
        extram_d_in[ST_RX_COUNT +: DEPTH_LOG2+1]   = rx_count;
        extram_d_in[ST_RX_OVF:ST_TX_ERR]           = flags;
      end
      REG_CTRL: begin
        extram_d_in[CT_IE_RX] = ie_rx;
        extram_d_in[CT_IE_TX] = ie_tx;
      end
      default: extram_d_in = '0;
    endcase
  end

endmodule

// File: tb/tb_extram_stream_bridge.sv
// Bench for extram_stream_bridge: directed register/stream scenarios plus
// randomized traffic checked every cycle against a queue-based model.
module tb_extram_stream_bridge;

  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LEVEL = 0;

  localparam logic [1:0] R_TX = 2'd0, R_RX = 2'd1, R_ST = 2'd2, R_CT = 2'd3;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] extram_a;
  logic [31:0] extram_d_out;
  logic        extram_cs, extram_oe;
  logic [3:0]  extram_wstrb;
  logic [31:0] extram_d_in;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        irq;

  always #5 clk = ~clk;

  extram_stream_bridge #(.DEPTH_LOG2(DL2), .TX_IRQ_LEVEL(LEVEL)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .extram_a     (extram_a),
    .extram_d_out (extram_d_out),
    .extram_cs    (extram_cs),
    .extram_oe    (extram_oe),
    .extram_wstrb (extram_wstrb),
    .extram_d_in  (extram_d_in),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .irq          (irq)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as queues, the word being sent, bytes gathered
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [31:0] m_word  = '0;
  bit          m_busy  = 0;
  int unsigned m_tidx  = 0;
  int unsigned m_ridx  = 0;
  logic [7:0]  m_bytes[4];
  logic [3:0]  m_flags = '0;
  bit          m_ie_rx = 0, m_ie_tx = 0, m_irq = 0;

  task automatic bus_idle();
    extram_cs    = 1'b0;
    extram_oe    = 1'b0;
    extram_wstrb = 4'h0;
    extram_a     = 16'($urandom);
    extram_d_out = $urandom;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    logic [11:0] hi;
    hi = 12'($urandom);
    extram_cs    = 1'b1;
    extram_oe    = 1'b0;
    extram_wstrb = s;
    extram_a     = {hi, r, 2'b00};
    extram_d_out = d;
  endtask

  task automatic bus_read(input logic [1:0] r);
    logic [11:0] hi;
    hi = 12'($urandom);
    extram_cs    = 1'b1;
    extram_oe    = 1'b1;
    extram_wstrb = 4'h0;
    extram_a     = {hi, r, 2'b00};
    extram_d_out = $urandom;
  endtask

  // One clock: compare outputs at the negedge, then advance the model to the posedge.
  task automatic cycle();
    bit          rd, wr, rd_rx, txf, rxf, tx_pop, acc, rdy, irq_n, do_push;
    logic [1:0]  a;
    logic [31:0] exp_d, t, popped;
    logic [3:0]  set, clr;
    @(negedge clk);
    a     = extram_a[3:2];
    rd    = extram_cs && extram_oe;
    wr    = extram_cs && (extram_wstrb != 4'h0);
    rd_rx = rd && a == R_RX;
    rdy   = !nrst && !(m_ridx == 3 && rxq.size() == DEPTH && !(rd_rx && rxq.size() != 0));
    t     = m_word >> (8 * m_tidx);
    check("tx_valid", 32'(tx_valid), 32'(m_busy));
    check("tx_data", 32'(tx_data), m_busy ? 32'(t[7:0]) : 32'h0);
    check("rx_ready", 32'(rx_ready), 32'(rdy));
    check("irq", 32'(irq), 32'(m_irq));
    if (rd) begin
      case (a)
        R_RX:    exp_d = (rxq.size() != 0) ? rxq[0] : 32'h0;
        R_ST:    exp_d = 32'(txq.size()) | (32'(rxq.size()) << 16) | (32'(m_flags) << 8);
        R_CT:    exp_d = {22'h0, m_ie_tx, m_ie_rx, 8'h00};
        default: exp_d = 32'h0;
      endcase
      check("read_data", extram_d_in, exp_d);
    end
    if (nrst) begin
      txq.delete(); rxq.delete();
      m_busy = 0; m_tidx = 0; m_ridx = 0; m_word = '0;
      m_flags = '0; m_ie_rx = 0; m_ie_tx = 0; m_irq = 0;
    end else begin
      irq_n = (m_ie_rx && rxq.size() != 0) || (m_ie_tx && txq.size() <= LEVEL);
      txf = wr && a == R_CT && extram_wstrb[0] && extram_d_out[0];
      rxf = wr && a == R_CT && extram_wstrb[0] && extram_d_out[1];
      set = 4'h0;
      clr = (wr && a == R_ST && extram_wstrb[1]) ? extram_d_out[11:8] : 4'h0;
      tx_pop  = txq.size() != 0 && (!m_busy || (tx_ready && m_tidx == 3));
      do_push = 0;
      if (wr && a == R_TX) begin
        if (extram_wstrb != 4'hF) set[0] = 1;
        else if (txq.size() == DEPTH && !tx_pop) set[1] = 1;
        else do_push = 1;
      end
      if (txf) begin
        txq.delete(); m_busy = 0; m_tidx = 0;
      end else begin
        popped = '0;
        if (tx_pop) popped = txq.pop_front();
        if (do_push) txq.push_back(extram_d_out);
        if (tx_pop) begin
          m_word = popped; m_busy = 1; m_tidx = 0;
        end else if (m_busy && tx_ready) begin
          if (m_tidx == 3) m_busy = 0;
          else m_tidx++;
        end
      end
      acc = rx_valid && rdy;
      if (rxf) begin
        if (acc && m_ridx == 3) set[3] = 1;
        rxq.delete(); m_ridx = 0;
      end else begin
        if (rd_rx) begin
          if (rxq.size() != 0) void'(rxq.pop_front());
          else set[2] = 1;
        end
        if (acc) begin
          m_bytes[m_ridx] = rx_data;
          if (m_ridx == 3) begin
            rxq.push_back({rx_data, m_bytes[2], m_bytes[1], m_bytes[0]});
            m_ridx = 0;
          end else m_ridx++;
        end
      end
      if (wr && a == R_CT && extram_wstrb[1]) begin
        m_ie_rx = extram_d_out[8];
        m_ie_tx = extram_d_out[9];
      end
      m_flags = (m_flags & ~clr) | set;
      m_irq   = irq_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cycle(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    bus_write(r, d, s);
    cycle();
    bus_idle();
  endtask

  task automatic rd_check(input string tag, input logic [1:0] r, input logic [31:0] exp);
    bus_read(r);
    #1;
    check(tag, extram_d_in, exp);
    cycle();
    bus_idle();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cycle();
    rx_valid = 1'b0;
  endtask

  int unsigned tr[4]  = '{20, 85, 50, 60};
  int unsigned rv[4]  = '{50, 90, 50, 60};
  int unsigned wtx[4] = '{40, 5, 25, 20};
  int unsigned wrx[4] = '{5, 8, 25, 20};

  initial begin
    logic [31:0] w;
    logic [31:0] cd;
    int unsigned r;
    nrst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus_idle();
    @(posedge clk); #1;
    cycle(); cycle();
    nrst = 1'b0;
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'h1);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rd_check("rst_status", R_ST, 32'h0);
    rd_check("rst_ctrl", R_CT, 32'h0);

    // Single word out, little-endian, two cycles after the write
    tx_ready = 1'b1;
    wr_cycle(R_TX, 32'h44332211, 4'hF);
    check("tx_lat_idle", 32'(tx_valid), 32'h0);
    cycle();
    w = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      check("tx_seq_valid", 32'(tx_valid), 32'h1);
      check("tx_seq_byte", 32'(tx_data), 32'(w[8*i +: 8]));
      cycle();
    end
    check("tx_seq_done", 32'(tx_valid), 32'h0);

    // Fill TX with a stalled sink: one word held by the serializer, 16 queued
    tx_ready = 1'b0;
    for (int k = 1; k <= 17; k++) wr_cycle(R_TX, 32'(k), 4'hF);
    rd_check("tx_full_count", R_ST, 32'h0000_0010);
    wr_cycle(R_TX, 32'hDEAD_BEEF, 4'hF);
    rd_check("tx_ovf_set", R_ST, 32'h0000_0210);
    wr_cycle(R_ST, 32'h0000_0200, 4'hF);
    rd_check("tx_ovf_w1c", R_ST, 32'h0000_0010);
    wr_cycle(R_CT, 32'h0000_0001, 4'h1);
    rd_check("tx_flush", R_ST, 32'h0);
    check("tx_flush_valid", 32'(tx_valid), 32'h0);

    // RX word assembly and underflow
    rx_byte(8'hAA); rx_byte(8'hBB); rx_byte(8'hCC); rx_byte(8'hDD);
    rd_check("rx_count_one", R_ST, 32'h0001_0000);
    rd_check("rx_word", R_RX, 32'hDDCC_BBAA);
    rd_check("rx_count_zero", R_ST, 32'h0);
    rd_check("rx_empty_read", R_RX, 32'h0);
    rd_check("rx_unf_set", R_ST, 32'h0000_0400);
    wr_cycle(R_ST, 32'h0000_0400, 4'hF);

    // RX backpressure only at byte 3 with the FIFO full; a read releases it
    rx_valid = 1'b1;
    for (int i = 0; i < 67; i++) begin
      rx_data = 8'($urandom);
      cycle();
    end
    rx_valid = 1'b0;
    check("rx_ready_full", 32'(rx_ready), 32'h0);
    bus_read(R_RX);
    #1;
    check("rx_ready_on_pop", 32'(rx_ready), 32'h1);
    rx_valid = 1'b1; rx_data = 8'h5A;
    cycle();
    rx_valid = 1'b0;
    bus_idle();
    rd_check("rx_full_after_pop", R_ST, 32'h0010_0000);
    wr_cycle(R_CT, 32'h0000_0002, 4'h1);
    rd_check("rx_flush", R_ST, 32'h0);

    // Partial-strobe TXDATA write and the TX-low interrupt
    wr_cycle(R_TX, 32'h1234_5678, 4'b0011);
    rd_check("tx_err_set", R_ST, 32'h0000_0100);
    wr_cycle(R_CT, 32'h0000_0200, 4'b0010);
    check("irq_latency", 32'(irq), 32'h0);
    cycle();
    check("irq_tx_low", 32'(irq), 32'h1);
    wr_cycle(R_CT, 32'h0, 4'hF);
    wr_cycle(R_ST, 32'h0000_0F00, 4'hF);

    // Reset mid-word abandons the partial bytes
    rx_byte(8'h01); rx_byte(8'h02);
    nrst = 1'b1;
    cycle();
    check("rx_ready_in_reset", 32'(rx_ready), 32'h0);
    nrst = 1'b0;
    #1;
    check("rx_ready_after_reset", 32'(rx_ready), 32'h1);
    rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h30); rx_byte(8'h40);
    rd_check("rx_count_after_reset", R_ST, 32'h0001_0000);
    rd_check("rx_clean_word", R_RX, 32'h4030_2010);

    // Randomized traffic in phases biased towards TX-full, RX-full, mixed, resets
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 800; c++) begin
        r        = $urandom_range(0, 99);
        tx_ready = ($urandom_range(0, 99) < tr[p]);
        rx_valid = ($urandom_range(0, 99) < rv[p]);
        rx_data  = 8'($urandom);
        nrst     = (p == 3) && ($urandom_range(0, 199) == 0);
        if (r < wtx[p]) begin
          bus_write(R_TX, $urandom,
                    ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 14)) : 4'hF);
        end else if (r < wtx[p] + wrx[p]) begin
          bus_read(R_RX);
        end else if (r < wtx[p] + wrx[p] + 8) begin
          bus_read(R_ST);
        end else if (r < wtx[p] + wrx[p] + 11) begin
          bus_write(R_ST, $urandom, 4'hF);
        end else if (r < wtx[p] + wrx[p] + 15) begin
          cd = 32'($urandom_range(0, 3)) << 8;
          if ($urandom_range(0, 19) == 0) cd = cd | 32'($urandom_range(1, 3));
          bus_write(R_CT, cd, 4'($urandom_range(1, 15)));
        end else if (r < wtx[p] + wrx[p] + 18) begin
          bus_read(R_CT);
        end else if (r < wtx[p] + wrx[p] + 20) begin
          bus_read(R_TX);
        end else begin
          bus_idle();
        end
        cycle();
      end
    end

    nrst = 1'b0;
    bus_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
